// File: rtl/npu_act_pipe.sv
// npu_act_pipe: two-stage signed fixed-point activation stage with a
// valid/ready handshake on both sides.
// Optional build macro NPU_ACT_ROUND_EN: the arithmetic right shifts used by
// the leaky and hard-sigmoid paths round half-up instead of truncating.
module npu_act_pipe #(
   parameter int DWidth     = 32,
   parameter int FracBits   = 16,
   parameter int LeakyShift = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [1:0]        type_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DWidth-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DWidth-1:0] out_data_o,
   output logic              busy_o,
   output logic [15:0]       done_cnt_o
);

   typedef enum logic [1:0] {
      ACT_IDENT = 2'd0,
      ACT_RELU  = 2'd1,
      ACT_LEAKY = 2'd2,
      ACT_HSIG  = 2'd3
   } act_e;

   localparam logic signed [DWidth-1:0] One  = DWidth'(1) << FracBits;
   localparam logic signed [DWidth-1:0] Half = DWidth'(1) << (FracBits - 1);

   // Arithmetic right shift; optionally biased by half an LSB so it rounds half-up.
   function automatic logic signed [DWidth-1:0] asr(input logic signed [DWidth-1:0] v,
                                                    input int s);
      logic signed [DWidth-1:0] b;
`ifdef NPU_ACT_ROUND_EN
      b = v + (DWidth'(1) << (s - 1));
`else
      b = v;
`endif
      return b >>> s;
   endfunction

   // Stage-1 state
   logic                     s1_valid_q;
   logic signed [DWidth-1:0] s1_x_q;
   act_e                     s1_type_q;
   logic signed [DWidth-1:0] s1_leaky_q;
   logic signed [DWidth-1:0] s1_sig_q;
   logic                     s1_neg_q;

   // Stage-2 (output) state
   logic                     out_valid_q;
   logic [DWidth-1:0]        out_data_q;
   logic [15:0]              done_cnt_q;

   logic                     s1_en;
   logic                     s2_en;
   logic signed [DWidth-1:0] x_in;
   logic signed [DWidth-1:0] sig_sum;
   logic signed [DWidth-1:0] y_d;

   assign x_in  = $signed(in_data_i);
   // Stage 2 advances when empty or when the consumer takes its word;
   // stage 1 advances when empty or when stage 2 advances (bubble collapse).
   assign s2_en = !out_valid_q || out_ready_i;
   assign s1_en = !s1_valid_q || s2_en;

   assign in_ready_o  = s1_en;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign busy_o      = s1_valid_q || out_valid_q;
   assign done_cnt_o  = done_cnt_q;

   // Stage-2 combinational select and hard-sigmoid clamp.
   always_comb begin
      sig_sum = s1_sig_q + Half;
      y_d     = s1_x_q;
      unique case (s1_type_q)
         ACT_IDENT: y_d = s1_x_q;
         ACT_RELU:  y_d = s1_neg_q ? '0 : s1_x_q;
         ACT_LEAKY: y_d = s1_neg_q ? s1_leaky_q : s1_x_q;
         ACT_HSIG: begin
            if (sig_sum < 0)
               y_d = '0;
            else if (sig_sum > One)
               y_d = One;
            else
               y_d = sig_sum;
         end
         default:   y_d = s1_x_q;
      endcase
   end

   // Stage 1: capture the word, its type and the pre-shifted terms on acceptance.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_x_q     <= '0;
         s1_type_q  <= ACT_IDENT;
         s1_leaky_q <= '0;
         s1_sig_q   <= '0;
         s1_neg_q   <= 1'b0;
      end else if (s1_en) begin
         s1_valid_q <= in_valid_i;
         if (in_valid_i) begin
            s1_x_q     <= x_in;
            s1_type_q  <= act_e'(type_i);
            s1_leaky_q <= asr(x_in, LeakyShift);
            s1_sig_q   <= asr(x_in, 2);
            s1_neg_q   <= x_in[DWidth-1];
         end
      end
   end

   // Stage 2: register the selected result; holds while the consumer stalls.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (s2_en) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q)
            out_data_q <= y_d;
      end
   end

   // Output transfer counter, wraps naturally at 16 bits.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         done_cnt_q <= '0;
      else if (out_valid_q && out_ready_i)
         done_cnt_q <= done_cnt_q + 16'd1;
   end

endmodule

// File: tb/tb_npu_act_pipe.sv
// tb_npu_act_pipe: directed and randomized checks of npu_act_pipe against a
// behavioural activation model built from plain integer arithmetic.
module tb_npu_act_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  type_s;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        busy;
   logic [15:0] done_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   bit          last_acc;

   always #5 clk = ~clk;

   npu_act_pipe dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .type_i      (type_s),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .busy_o      (busy),
      .done_cnt_o  (done_cnt)
   );

   // Divide by 2^s with floor semantics, optionally adding half first (32-bit wrap).
   function automatic longint shift_ref(input logic signed [31:0] v, input int s);
      longint d;
      longint n;
      longint q;
      logic signed [31:0] t;
      d = longint'(1) << s;
`ifdef NPU_ACT_ROUND_EN
      t = v + 32'(d / 2);
`else
      t = v;
`endif
      n = longint'(t);
      q = n / d;
      if ((n % d) != 0 && n < 0)
         q = q - 1;
      return q;
   endfunction

   function automatic logic [31:0] act_ref(input logic signed [31:0] x, input logic [1:0] t);
      longint v;
      v = longint'(x);
      case (t)
         2'd0: v = longint'(x);
         2'd1: v = (x < 0) ? 0 : longint'(x);
         2'd2: v = (x < 0) ? shift_ref(x, 3) : longint'(x);
         default: begin
            v = shift_ref(x, 2) + 32768;
            if (v < 0) v = 0;
            if (v > 65536) v = 65536;
         end
      endcase
      return 32'(v);
   endfunction

   // Advance one clock; record handshakes seen mid-cycle into the scoreboard queues.
   task automatic cycle();
      @(negedge clk);
      last_acc = in_valid && in_ready;
      if (last_acc)
         exp_q.push_back(act_ref($signed(in_data), type_s));
      if (out_valid && out_ready)
         got_q.push_back(out_data);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_reset();
      out_ready = 1'b1;
      apply_reset();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
      n_checks++; if (done_cnt !== 16'd0) $display("FAIL reset_done_cnt got=%0d exp=0", done_cnt); else n_pass++;
      n_checks++; if (out_data !== 32'd0) $display("FAIL reset_out_data got=%h exp=0", out_data); else n_pass++;
      $display("test_reset done");
   endtask

   // Types, clamp and leaky rounding with exact latency: word driven in cycle c
   // is visible on the output in cycle c+2.
   task automatic test_directed();
      logic [31:0] vx[7];
      logic [1:0]  vt[7];
      logic [31:0] ve[7];
      vx[0] = 32'hFFFF0000; vt[0] = 2'd0; ve[0] = 32'hFFFF0000;
      vx[1] = 32'hFFFF0000; vt[1] = 2'd1; ve[1] = 32'h00000000;
      vx[2] = 32'hFFFF0000; vt[2] = 2'd2; ve[2] = 32'hFFFFE000;
      vx[3] = 32'hFFFF0000; vt[3] = 2'd3; ve[3] = 32'h00004000;
      vx[4] = 32'h00040000; vt[4] = 2'd3; ve[4] = 32'h00010000;
      vx[5] = 32'hFFFC0000; vt[5] = 2'd3; ve[5] = 32'h00000000;
      vx[6] = 32'hFFFFFFFD; vt[6] = 2'd2;
`ifdef NPU_ACT_ROUND_EN
      ve[6] = 32'h00000000;
`else
      ve[6] = 32'hFFFFFFFF;
`endif
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_data  = vx[i];
         type_s   = vt[i];
         cycle();
         in_valid = 1'b0;
         n_checks++;
         if (out_valid !== 1'b0)
            $display("FAIL dir%0d_early_valid got=%b exp=0", i, out_valid);
         else n_pass++;
         cycle();
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== ve[i])
            $display("FAIL dir%0d_result x=%h t=%0d got valid=%b data=%h exp valid=1 data=%h",
                     i, vx[i], vt[i], out_valid, out_data, ve[i]);
         else n_pass++;
         cycle();
         $display("test_directed vec%0d x=%h type=%0d out=%h", i, vx[i], vt[i], out_data);
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_backpressure();
      logic [31:0] w[4];
      logic [1:0]  wt[4];
      int          idx;
      int          cyc;
      logic [15:0] done0;
      done0 = done_cnt;
      for (int i = 0; i < 4; i++) begin
         w[i]  = $urandom;
         wt[i] = 2'($urandom_range(0, 3));
      end
      idx = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         in_valid = (idx < 4);
         in_data  = w[idx % 4];
         type_s   = wt[idx % 4];
         cycle();
         if (last_acc) idx++;
         if (c >= 1) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== exp_q[0])
               $display("FAIL bp_stall c=%0d got rdy=%b vld=%b data=%h exp rdy=0 vld=1 data=%h",
                        c, in_ready, out_valid, out_data, exp_q[0]);
            else n_pass++;
         end
      end
      n_checks++;
      if (idx !== 2) $display("FAIL bp_accepts got=%0d exp=2", idx); else n_pass++;
      out_ready = 1'b1;
      cyc = 0;
      while (got_q.size() < 4 && cyc < 20) begin
         in_valid = (idx < 4);
         in_data  = w[idx % 4];
         type_s   = wt[idx % 4];
         cycle();
         if (last_acc) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (got_q.size() != 4) $display("FAIL bp_count got=%0d exp=4", got_q.size()); else n_pass++;
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== act_ref($signed(w[i]), wt[i]))
            $display("FAIL bp_order%0d got=%h exp=%h", i, got_q[i], act_ref($signed(w[i]), wt[i]));
         else n_pass++;
      end
      n_checks++;
      if (done_cnt !== done0 + 16'd4)
         $display("FAIL bp_done_cnt got=%0d exp=%0d", done_cnt, done0 + 16'd4);
      else n_pass++;
      $display("test_backpressure accepted=%0d emitted=%0d done_cnt=%0d", idx, got_q.size(), done_cnt);
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_type_change();
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 32'hFFFF0000; type_s = 2'd1;
      cycle();
      type_s = 2'd0;
      cycle();
      in_valid = 1'b0;
      repeat (3) cycle();
      n_checks++;
      if (got_q.size() != 2) $display("FAIL tc_count got=%0d exp=2", got_q.size()); else n_pass++;
      if (got_q.size() == 2) begin
         n_checks++;
         if (got_q[0] !== 32'h00000000) $display("FAIL tc_first got=%h exp=00000000", got_q[0]); else n_pass++;
         n_checks++;
         if (got_q[1] !== 32'hFFFF0000) $display("FAIL tc_second got=%h exp=ffff0000", got_q[1]); else n_pass++;
         $display("test_type_change first=%h second=%h", got_q[0], got_q[1]);
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_random();
      logic [15:0] done0;
      int          cyc;
      int          sel;
      done0 = done_cnt;
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         type_s    = 2'($urandom_range(0, 3));
         sel       = $urandom_range(0, 2);
         if (sel == 0)      in_data = $urandom;
         else if (sel == 1) in_data = 32'($signed($urandom_range(0, 32'h60000)) - 32'sh30000);
         else               in_data = 32'($signed($urandom_range(0, 32)) - 32'sd16);
         cycle();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      while (got_q.size() < exp_q.size() && cyc < 10) begin
         cycle();
         cyc++;
      end
      n_checks++;
      if (got_q.size() != exp_q.size())
         $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL rnd_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (done_cnt !== 16'(done0 + got_q.size()))
         $display("FAIL rnd_done_cnt got=%0d exp=%0d", done_cnt, 16'(done0 + got_q.size()));
      else n_pass++;
      $display("test_random words=%0d done_cnt=%0d", got_q.size(), done_cnt);
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_data = $urandom;
         type_s  = 2'd0;
         cycle();
      end
      out_ready = 1'b1;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         cycle();
         n_checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL rstmid_idle%0d got vld=%b busy=%b exp vld=0 busy=0", i, out_valid, busy);
         else n_pass++;
      end
      n_checks++;
      if (got_q.size() != 0) $display("FAIL rstmid_leak got=%0d exp=0", got_q.size()); else n_pass++;
      n_checks++;
      if (done_cnt !== 16'd0) $display("FAIL rstmid_done_cnt got=%0d exp=0", done_cnt); else n_pass++;
      $display("test_reset_midstream emitted_after_reset=%0d", got_q.size());
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_wrap();
      int total;
      total = 70000;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      type_s    = 2'd0;
      for (int i = 0; i < total; i++) begin
         in_data = 32'(i);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (done_cnt !== 16'(total % 65536))
         $display("FAIL wrap_done_cnt got=%0d exp=%0d", done_cnt, total % 65536);
      else n_pass++;
      $display("test_wrap transfers=%0d done_cnt=%0d", total, done_cnt);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      type_s = '0;
      out_ready = 1'b1;
      test_reset();
      test_directed();
      test_backpressure();
      test_type_change();
      test_random();
      test_reset_midstream();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
